// File: rtl/serial_compare6_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states and default width.
package serial_compare6_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_compare6_bit_equal.sv
// One-bit equality cell: y is high when both inputs agree.
module bit_equal (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/serial_compare6.sv
// Bit-serial unsigned comparator: deserialises two LSB-first operands and
// reports eq/gt/lt plus a per-bit match vector once all WIDTH pairs arrive.
module serial_compare6
    import serial_compare6_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [WIDTH-1:0] match,
    output logic [WIDTH-1:0] a_word,
    output logic [WIDTH-1:0] b_word
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             bit_match;
    logic [WIDTH-1:0] match_new;

    bit_equal u_bit_equal (
        .a (a_bit),
        .b (b_bit),
        .y (bit_match)
    );

    // Match vector including the pair on the inputs, so eq can be taken on the final edge.
    always_comb begin
        match_new      = match;
        match_new[cnt] = bit_match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            match  <= '0;
            a_word <= '0;
            b_word <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        eq     <= 1'b0;
                        gt     <= 1'b0;
                        lt     <= 1'b0;
                        match  <= '0;
                        a_word <= '0;
                        b_word <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        match       <= match_new;
                        a_word[cnt] <= a_bit;
                        b_word[cnt] <= b_bit;
                        // Pairs arrive LSB first, so a later difference is more significant.
                        if (a_bit != b_bit) begin
                            gt <= a_bit;
                            lt <= b_bit;
                        end
                        if (cnt == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            eq    <= &match_new;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare6.sv
// Directed bench for serial_compare6: table of operand pairs plus reset/start corner sequences.
module tb_serial_compare6;

    logic       clk = 1'b0;
    logic       reset, start, bit_valid, a_bit, b_bit;
    logic       busy, done, eq, gt, lt;
    logic [5:0] match, a_word, b_word;

    int checks = 0;
    int errors = 0;

    serial_compare6 #(.WIDTH(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .match     (match),
        .a_word    (a_word),
        .b_word    (b_word)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        bit         gap;
        bit         mid_start;
        logic       eq;
        logic       gt;
        logic       lt;
        logic [5:0] m;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_results(input string tag, input vec_t v);
        chk({tag, " eq"},     32'(eq),     32'(v.eq));
        chk({tag, " gt"},     32'(gt),     32'(v.gt));
        chk({tag, " lt"},     32'(lt),     32'(v.lt));
        chk({tag, " match"},  32'(match),  32'(v.m));
        chk({tag, " a_word"}, 32'(a_word), 32'(v.a));
        chk({tag, " b_word"}, 32'(b_word), 32'(v.b));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " eq/gt/lt"}, 32'({eq, gt, lt}), 32'(0));
        chk({tag, " words"},    32'({match, a_word, b_word}), 32'(0));
    endtask

    // Runs one comparison from IDLE/DONE; returns at the negedge of the done cycle.
    task automatic run_cmp(input vec_t v);
        // start with a mismatching valid pair: the pair must not be consumed
        start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        step();
        start = 1'b0; bit_valid = 1'b0;
        chk("busy after start", 32'(busy), 32'(1));
        chk_cleared("after start");
        for (int i = 0; i < 6; i++) begin
            if (v.gap) begin
                bit_valid = 1'b0; a_bit = ~v.a[i]; b_bit = v.b[i];
                step();
            end
            bit_valid = 1'b1; a_bit = v.a[i]; b_bit = v.b[i];
            start = (v.mid_start && i == 2);
            if (i == 5) chk("done before last pair", 32'(done), 32'(0));
            step();
            start = 1'b0;
        end
        bit_valid = 1'b0;
        chk("done pulse", 32'(done), 32'(1));
        chk("busy at done", 32'(busy), 32'(0));
        chk_results("done", v);
    endtask

    initial begin
        vecs[0] = '{a: 6'b101010, b: 6'b101010, gap: 0, mid_start: 0, eq: 1, gt: 0, lt: 0, m: 6'b111111};
        vecs[1] = '{a: 6'b100111, b: 6'b100100, gap: 0, mid_start: 0, eq: 0, gt: 1, lt: 0, m: 6'b111100};
        vecs[2] = '{a: 6'b000001, b: 6'b100000, gap: 0, mid_start: 0, eq: 0, gt: 0, lt: 1, m: 6'b011110};
        vecs[3] = '{a: 6'b110011, b: 6'b110011, gap: 1, mid_start: 0, eq: 1, gt: 0, lt: 0, m: 6'b111111};
        vecs[4] = '{a: 6'b111111, b: 6'b000000, gap: 0, mid_start: 0, eq: 0, gt: 1, lt: 0, m: 6'b000000};
        vecs[5] = '{a: 6'b011111, b: 6'b100000, gap: 1, mid_start: 0, eq: 0, gt: 0, lt: 1, m: 6'b000000};
        vecs[6] = '{a: 6'b000000, b: 6'b000000, gap: 0, mid_start: 1, eq: 1, gt: 0, lt: 0, m: 6'b111111};
        vecs[7] = '{a: 6'b010101, b: 6'b010100, gap: 0, mid_start: 1, eq: 0, gt: 1, lt: 0, m: 6'b111110};

        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        @(negedge clk);
        step();
        chk("reset busy/done", 32'({busy, done}), 32'(0));
        chk_cleared("reset");
        reset = 1'b0;

        // Main table; each run is followed by a hold cycle with junk valid pairs in IDLE.
        for (int k = 0; k < 8; k++) begin
            run_cmp(vecs[k]);
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            step();
            bit_valid = 1'b0;
            chk("done one cycle", 32'(done), 32'(0));
            chk("idle busy", 32'(busy), 32'(0));
            chk_results("held", vecs[k]);
        end

        // Reset after 3 pairs aborts without a done pulse.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            step();
        end
        bit_valid = 1'b1;
        reset = 1'b1;
        step();
        chk("abort busy/done", 32'({busy, done}), 32'(0));
        chk_cleared("abort");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort no done", 32'({busy, done}), 32'(0));
        end
        bit_valid = 1'b0;
        run_cmp(vecs[1]);

        // start in the DONE cycle restarts immediately.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart busy", 32'(busy), 32'(1));
        chk("restart done", 32'(done), 32'(0));
        chk_cleared("restart");
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1; a_bit = vecs[2].a[i]; b_bit = vecs[2].b[i];
            step();
        end
        bit_valid = 1'b0;
        chk("restart done pulse", 32'(done), 32'(1));
        chk_results("restart", vecs[2]);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_compare6.md
SERIAL_COMPARE6 -- requirements
Module: serial_compare6

Interface
REQ-001 Parameter WIDTH, default 6, is the operand width in bits.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 reset  input  1  Reset is synchronous and active-high.
REQ-004 start  input  1  Request to begin a new comparison.
REQ-005 bit_valid  input  1  a_bit/b_bit carry a valid operand bit pair this cycle.
REQ-006 a_bit  input  1  Serial operand A, LSB first.
REQ-007 b_bit  input  1  Serial operand B, LSB first.
REQ-008 busy  output  1  High while in SHIFT state.
REQ-009 done  output  1  One-cycle pulse when a result becomes valid.
REQ-010 eq  output  1  Operands equal: every received bit pair matched.
REQ-011 gt  output  1  A > B, unsigned.
REQ-012 lt  output  1  A < B, unsigned.
REQ-013 match  output  WIDTH  Per-bit equality vector; match[i] = XNOR(A[i], B[i]).
REQ-014 a_word, b_word  output  WIDTH each  Deserialised operands.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 IDLE: on start=1, go to SHIFT and clear bit counter, match, a_word, b_word, eq/gt/lt. Otherwise hold all results.
REQ-017 SHIFT: each cycle with bit_valid=1 consumes one pair at index = counter. Cycles with bit_valid=0 stall without change; there is no timeout.
REQ-018 Per consumed pair at index i:
- match[i] <= XNOR(a_bit, b_bit)
- a_word[i] <= a_bit; b_word[i] <= b_bit
- if a_bit != b_bit: gt <= a_bit, lt <= b_bit (a later, more significant difference overrides an earlier one)
REQ-019 When the WIDTH-th pair is consumed (counter = WIDTH-1), the next state SHALL be DONE.
REQ-020 DONE lasts exactly one cycle, with done=1 and eq = (match == all ones). The next state SHALL be IDLE.
REQ-021 Latency SHALL be exactly one cycle from the clock edge that consumes the last pair to done=1.
REQ-022 eq, gt, lt, match, a_word and b_word SHALL be valid from the done cycle and held until the next accepted start.
REQ-023 At done, exactly one of eq/gt/lt SHALL be 1.
REQ-024 start in SHIFT SHALL be ignored; the comparison in progress continues.
REQ-025 start in DONE SHALL be accepted as in IDLE: the state goes to SHIFT and results clear.
REQ-026 bit_valid in IDLE or DONE SHALL be ignored.
REQ-027 If start and bit_valid are both 1 in IDLE, only start acts; the bit pair is not consumed.
REQ-028 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE and zero the counter, busy, done, eq, gt, lt, match, a_word and b_word. Reset takes priority over all other inputs.
REQ-030 Reset asserted mid-SHIFT SHALL abort the comparison with no done pulse.
REQ-031 The first start after reset release SHALL be honoured on the first edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration (IDLE, SHIFT, DONE) and the default width constant of 6.
REQ-033 A one-bit equality cell sub-module, bit_equal (XNOR of two bits), SHALL produce the match bit. The FSM, counter and registers SHALL reside in serial_compare6.

Verification
REQ-034 A=101010, B=101010 sent LSB-first with continuous bit_valid -> done 7 cycles after the start edge, eq=1, gt=0, lt=0, match=111111.
REQ-035 A=100111, B=100100 -> gt=1, eq=0, lt=0, match=111100, a_word=100111, b_word=100100.
REQ-036 A=000001, B=100000 (LSB difference overridden by MSB difference) -> lt=1, gt=0, match=011110.
REQ-037 A=110011, B=110011 with bit_valid low on alternating cycles -> eq=1; done occurs exactly one cycle after the 6th valid pair.
REQ-038 Assert reset after 3 pairs -> no done pulse, all outputs 0. A following start plus a full pair sequence then completes correctly.
REQ-039 start pulsed during SHIFT -> ignored, result unchanged. start asserted in the DONE cycle -> busy=1 on the next cycle and results cleared.
